// File: rtl/vga_pkg.sv
// Shared VGA timing constants and color types used by the scan controller.
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;

   localparam int COLOR_W = 12;
   localparam int CH_W    = 4;

   typedef logic [COLOR_W-1:0] color_t;

   typedef struct packed {
      logic [CH_W-1:0] r;
      logic [CH_W-1:0] g;
      logic [CH_W-1:0] b;
   } rgb_t;

   // 32-pixel checkerboard cell color from bit 5 of the scan coordinates.
   function automatic color_t checker_color(input logic x_bit, input logic y_bit);
      return (x_bit ^ y_bit) ? 12'hFFF : 12'h000;
   endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Pixel-tick generator: one-clk tick every CLK_DIV clocks, asynchronous active-low reset.
module vga_tick_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic tick_o
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/vga_scan_controller.sv
// Raster-scan VGA front end: scan counters, row-major pixel address, and pins re-aligned one tick later.
// Defining VGA_TEST_PATTERN_EN adds a test_mode input that swaps colorData for a checkerboard.
module vga_scan_controller
   import vga_pkg::*;
#(
   parameter int WIDTH               = H_ACTIVE,
   parameter int HEIGHT              = V_ACTIVE,
   parameter int CLK_DIV             = 4,
   parameter int RAM_LATENCY         = 2,
   parameter int PIXEL_ADDRESS_WIDTH = $clog2(WIDTH * HEIGHT) + 1
) (
   input  logic                           clk,
   input  logic                           reset_n,
`ifdef VGA_TEST_PATTERN_EN
   input  logic                           test_mode,
`endif
   input  logic [COLOR_W-1:0]             colorData,
   output logic [PIXEL_ADDRESS_WIDTH-1:0] imgAddress,
   output logic [9:0]                     x,
   output logic [9:0]                     y,
   output logic                           frame_done,
   output logic [CH_W-1:0]                vga_r,
   output logic [CH_W-1:0]                vga_g,
   output logic [CH_W-1:0]                vga_b,
   output logic                           vga_hs,
   output logic                           vga_vs
);

   localparam int H_SYNC_START = WIDTH + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int H_LAST       = H_SYNC_END + H_BP - 1;
   localparam int V_SYNC_START = HEIGHT + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
   localparam int V_LAST       = V_SYNC_END + V_BP - 1;

   // colorData is sampled one full tick after the address moves, so the RAM must settle within it.
   if (RAM_LATENCY >= CLK_DIV) begin : g_latency_check
      $error("RAM_LATENCY must be smaller than CLK_DIV");
   end

   logic tick;

   vga_tick_div #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_div (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .tick_o (tick)
   );

   logic [9:0]                     x_q, x_d;
   logic [9:0]                     y_q, y_d;
   logic [PIXEL_ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic                           hs_q, hs_d;
   logic                           vs_q, vs_d;
   logic                           frame_done_q, frame_done_d;
   color_t                         rgb_q, rgb_d;
   color_t                         pix_src;
   logic                           active_cur;
   rgb_t                           pin_rgb;

`ifdef VGA_TEST_PATTERN_EN
   assign pix_src = test_mode ? checker_color(x_q[5], y_q[5]) : colorData;
`else
   assign pix_src = colorData;
`endif

   assign active_cur = (x_q < 10'(WIDTH)) && (y_q < 10'(HEIGHT));

   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      addr_d = addr_q;
      if (tick) begin
         if (x_q == 10'(H_LAST)) begin
            x_d = '0;
            y_d = (y_q == 10'(V_LAST)) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
         // Address tracks y*WIDTH+x incrementally; it freezes through blanking.
         if ((x_d == '0) && (y_d == '0)) begin
            addr_d = '0;
         end else if ((x_d < 10'(WIDTH)) && (y_d < 10'(HEIGHT))) begin
            addr_d = addr_q + 1'b1;
         end
      end
   end

   // Pins describe the position the scan is leaving, so they lag x/y by one tick.
   always_comb begin
      hs_d         = hs_q;
      vs_d         = vs_q;
      rgb_d        = rgb_q;
      frame_done_d = 1'b0;
      if (tick) begin
         hs_d         = !((x_q >= 10'(H_SYNC_START)) && (x_q < 10'(H_SYNC_END)));
         vs_d         = !((y_q >= 10'(V_SYNC_START)) && (y_q < 10'(V_SYNC_END)));
         rgb_d        = active_cur ? pix_src : '0;
         frame_done_d = (x_q == 10'(H_LAST)) && (y_q == 10'(HEIGHT - 1));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q          <= '0;
         y_q          <= '0;
         addr_q       <= '0;
         hs_q         <= 1'b1;
         vs_q         <= 1'b1;
         rgb_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         addr_q       <= addr_d;
         hs_q         <= hs_d;
         vs_q         <= vs_d;
         rgb_q        <= rgb_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign pin_rgb    = rgb_q;
   assign x          = x_q;
   assign y          = y_q;
   assign imgAddress = addr_q;
   assign frame_done = frame_done_q;
   assign vga_r      = pin_rgb.r;
   assign vga_g      = pin_rgb.g;
   assign vga_b      = pin_rgb.b;
   assign vga_hs     = hs_q;
   assign vga_vs     = vs_q;

endmodule
